// File: rtl/uart_pkg.sv
// Shared definitions for the uart_tx arbiter: FSM state encoding, default beat width
// and the index-width helper used to size grant/pointer buses.
package uart_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    localparam int UART_N_BITS = 8;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: returns the first set request found
// scanning ptr, ptr+1, ... modulo N_REQ. Reusable by other shared-peripheral arbiters.
module rr_pick
    import uart_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]            req,
    input  logic [idx_width(N_REQ)-1:0] ptr,
    output logic [idx_width(N_REQ)-1:0] idx,
    output logic                        any
);

    localparam int IW = idx_width(N_REQ);

    logic [IW:0] sum;

    always_comb begin
        idx = '0;
        any = 1'b0;
        sum = '0;
        for (int i = 0; i < N_REQ; i++) begin
            // one spare bit keeps ptr+i from overflowing before the modulo wrap
            sum = {1'b0, ptr} + (IW+1)'(i);
            if (sum >= (IW+1)'(N_REQ)) begin
                sum = sum - (IW+1)'(N_REQ);
            end
            if (!any && req[sum[IW-1:0]]) begin
                any = 1'b1;
                idx = sum[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one uart_tx byte stream among N_REQ sources.
// Define ARB_TIMEOUT_EN to build a stall counter that force-releases an abandoned grant.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int N_BITS         = UART_N_BITS,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ*N_BITS-1:0]     s_tdata,
    input  logic [N_REQ-1:0]            s_tvalid,
    input  logic [N_REQ-1:0]            s_tlast,
    output logic [N_REQ-1:0]            s_tready,
    output logic [N_BITS-1:0]           m_tdata,
    output logic                        m_tvalid,
    input  logic                        m_tready,
    output logic [idx_width(N_REQ)-1:0] grant,
    output logic                        busy,
    output logic                        timeout
);

    localparam int             IW       = idx_width(N_REQ);
    localparam logic [IW-1:0]  LAST_IDX = IW'(N_REQ - 1);

    arb_state_e        state_q, state_d;
    logic [IW-1:0]     grant_q, grant_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic              timeout_q, timeout_d;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;
    logic [N_BITS-1:0] g_data;
    logic              g_valid, g_last;
    logic              beat_acc, stall_expire;

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("uart_tx_arbiter: unsupported parameter set");
    end

    rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .req (s_tvalid),
        .ptr (rr_ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        g_data  = '0;
        g_valid = 1'b0;
        g_last  = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant_q == IW'(k)) begin
                g_data  = s_tdata[k*N_BITS +: N_BITS];
                g_valid = s_tvalid[k];
                g_last  = s_tlast[k];
            end
        end
    end

    assign busy     = (state_q == ST_BUSY);
    assign m_tvalid = busy && g_valid;
    assign m_tdata  = busy ? g_data : '0;
    assign beat_acc = m_tvalid && m_tready;
    assign grant    = grant_q;
    assign timeout  = timeout_q;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
        // Only the owner sees uart_tx backpressure; s_tvalid never feeds s_tready.
        assign s_tready[gi] = busy && (grant_q == IW'(gi)) && m_tready;
    end

`ifdef ARB_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT_CYCLES + 1);

    logic [SW-1:0] stall_q, stall_d;

    always_comb begin
        stall_d      = stall_q;
        stall_expire = 1'b0;
        if (!busy || beat_acc) begin
            stall_d = '0;
        end else if (!g_valid) begin
            if (stall_q == SW'(TIMEOUT_CYCLES - 1)) begin
                stall_expire = 1'b1;
                stall_d      = '0;
            end else begin
                stall_d = stall_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end
`else
    assign stall_expire = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_BUSY;
                    grant_d = pick_idx;
                end
            end
            ST_BUSY: begin
                timeout_d = stall_expire;
                // a forced release advances the pointer exactly like a normal tlast
                if ((beat_acc && g_last) || stall_expire) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = (grant_q == LAST_IDX) ? '0 : grant_q + IW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            timeout_q <= timeout_d;
        end
    end

endmodule
